// File: rtl/qif_neuron_array_if.sv
// qif_neuron_array_if: valid/ready bus between the synaptic accumulator, the QIF neuron array and the spike router
// Parameters: W (signed data width), CH_W (channel index width)
// Signals:
//   in_valid/in_ready   input sample handshake
//   in_ch, I_syn        target neuron index and signed synaptic current
//   out_valid/out_ready result handshake
//   out_ch, V_mem       neuron index and signed membrane value of the result
//   spike               neuron fired on this sample
// Modports: master drives samples and accepts results; slave is the neuron array
interface qif_neuron_array_if #(
   parameter int W    = 8,
   parameter int CH_W = 2
);
   logic                   in_valid;
   logic                   in_ready;
   logic [CH_W-1:0]        in_ch;
   logic signed [W-1:0]    I_syn;
   logic                   out_valid;
   logic                   out_ready;
   logic [CH_W-1:0]        out_ch;
   logic signed [W-1:0]    V_mem;
   logic                   spike;
   modport master (
      output in_valid, in_ch, I_syn, out_ready,
      input  in_ready, out_valid, out_ch, V_mem, spike
   );
   modport slave (
      input  in_valid, in_ch, I_syn, out_ready,
      output in_ready, out_valid, out_ch, V_mem, spike
   );
endinterface

// File: rtl/qif_neuron_array.sv
// qif_neuron_array: time-multiplexed array of NUM_CH quadratic integrate-and-fire neurons on one shared datapath
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset, clears all neuron state and the output register
//   bus    qif_neuron_array_if slave: sample in (in_valid/in_ready/in_ch/I_syn),
//          result out (out_valid/out_ready/out_ch/V_mem/spike)
// Per sample: V' = V + (V*V >> A_SHIFT) + I_syn, with spike, reset and refractory handling.
module qif_neuron_array #(
   parameter int W       = 8,
   parameter int NUM_CH  = 4,
   parameter int A_SHIFT = 5,
   parameter int V_PEAK  = 50,
   parameter int V_RESET = -20,
   parameter int REFRAC  = 2
) (
   input logic               clk,
   input logic               rst_n,
   qif_neuron_array_if.slave bus
);
   localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
   localparam int RW   = REFRAC > 0 ? $clog2(REFRAC + 1) : 1;
   localparam logic signed [2*W:0] L_MAX  = (2*W+1)'(2**(W-1) - 1);
   localparam logic signed [2*W:0] L_MIN  = (2*W+1)'(-(2**(W-1)));
   localparam logic signed [2*W:0] L_PEAK = (2*W+1)'(V_PEAK);

   logic signed [W-1:0] r_v [NUM_CH];
   logic [RW-1:0]       r_rc [NUM_CH];
   logic                r_out_valid;
   logic                r_spike;
   logic [CH_W-1:0]     r_out_ch;
   logic signed [W-1:0] r_v_mem;

   logic                w_acc, w_ch_ok, w_ref, w_fire;
   logic [CH_W-1:0]     w_idx;
   logic signed [W-1:0] w_v, w_sat, w_v_nxt, w_mem;
   logic [2*W-1:0]      w_sq;
   logic signed [2*W:0] w_sum;
   logic [RW-1:0]       w_rc, w_rc_nxt;

   // one-deep output register: a new sample may enter whenever the held result leaves
   assign bus.in_ready  = !r_out_valid || bus.out_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.out_ch    = r_out_ch;
   assign bus.V_mem     = r_v_mem;
   assign bus.spike     = r_spike;

   assign w_acc   = bus.in_valid && bus.in_ready;
   assign w_ch_ok = 32'(bus.in_ch) < NUM_CH;
   // out-of-range samples are dropped; steer their read to a legal entry so nothing reads past the array
   assign w_idx   = w_ch_ok ? CH_W'(bus.in_ch) : '0;
   assign w_v     = r_v[w_idx];
   assign w_rc    = r_rc[w_idx];

   // the square of a W-bit signed value always fits 2W bits as unsigned; the sum is wide enough never to wrap
   assign w_sq  = (2*W)'(w_v) * (2*W)'(w_v);
   assign w_sum = (2*W+1)'(w_v) + $signed({1'b0, w_sq >> A_SHIFT}) + (2*W+1)'(bus.I_syn);
   assign w_sat = w_sum > L_MAX ? W'(L_MAX) : w_sum < L_MIN ? W'(L_MIN) : w_sum[W-1:0];

   // refractory wins over threshold; threshold uses the unsaturated sum
   assign w_ref    = w_rc != '0;
   assign w_fire   = !w_ref && w_sum >= L_PEAK;
   assign w_v_nxt  = (w_ref || w_fire) ? W'(V_RESET) : w_sat;
   assign w_rc_nxt = w_ref ? w_rc - 1'b1 : w_fire ? RW'(REFRAC) : '0;
   assign w_mem    = w_ref ? W'(V_RESET) : w_fire ? W'(V_PEAK) : w_sat;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < NUM_CH; k++) begin
            r_v[k]  <= '0;
            r_rc[k] <= '0;
         end
         r_out_valid <= 1'b0;
         r_out_ch    <= '0;
         r_v_mem     <= '0;
         r_spike     <= 1'b0;
      end else begin
         if (w_acc && w_ch_ok) begin
            r_v[w_idx]  <= w_v_nxt;
            r_rc[w_idx] <= w_rc_nxt;
            r_out_ch    <= w_idx;
            r_v_mem     <= w_mem;
            r_spike     <= w_fire;
         end
         if (bus.in_ready)
            r_out_valid <= w_acc && w_ch_ok;
      end
   end
endmodule
